tick_period_monitor: RTL

- Receiving end of the divider tick stream: consumes single-cycle tick pulses (nominally 1 per 25_000_000 clk_50mhz cycles) and measures the interval between them in clock cycles.
- Validates each interval against an expected period, declares lock after consecutive good intervals, and flags early, late or missing ticks.
- Sits beside the timebase in the zoom pipeline as a self-check for all tick-driven logic.

---
 rtl/tick_period_monitor.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tick_period_monitor.sv
// tick_period_monitor: measures the clk_50mhz cycle count between rising
// edges of a single-cycle tick stream, checks each interval against
// EXPECTED_PERIOD +/- TOLERANCE, declares lock after LOCK_COUNT good
// intervals and flags out-of-range and missing ticks.
// Optional min/max period statistics: define TICK_PERIOD_STATS_EN.
module tick_period_monitor #(
    parameter int unsigned EXPECTED_PERIOD = 25_000_000,
    parameter int unsigned TOLERANCE       = 16,
    parameter int unsigned LOCK_COUNT      = 2,
    parameter int unsigned CNT_W           = 27
) (
    input  logic             clk_50mhz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             err_range,
    output logic             err_timeout,
    output logic             err_sticky,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
);

    // The counter holds (cycles since last edge - 1), so the interval ending
    // on the current cycle is cnt + 1 and the timeout fires when it reaches
    // 2*EXPECTED_PERIOD.
    localparam int unsigned TIMEOUT_CNT = 2 * EXPECTED_PERIOD - 1;
    localparam int unsigned RUN_W       = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [RUN_W-1:0]   run;
    logic [RUN_W-1:0]   run_nxt;
    logic               tick_d;
    logic               tick_edge;
    logic [CNT_W-1:0]   period_now;
    logic [CNT_W-1:0]   diff;
    logic               in_range;
    logic [CNT_W-1:0]   period_nxt;
    logic               valid_nxt;
    logic               locked_nxt;
    logic               range_nxt;
    logic               tmo_nxt;
    logic               sticky_nxt;

    // Rising-edge detect and range check of the interval ending this cycle
    always_comb begin
        tick_edge  = tick_in & ~tick_d;
        period_now = cnt + CNT_W'(1);
        if (period_now >= CNT_W'(EXPECTED_PERIOD)) begin
            diff = period_now - CNT_W'(EXPECTED_PERIOD);
        end else begin
            diff = CNT_W'(EXPECTED_PERIOD) - period_now;
        end
        in_range = (diff <= CNT_W'(TOLERANCE));
    end

    // Next-state and next-output logic; en=0 overrides everything
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        run_nxt    = run;
        period_nxt = period_out;
        locked_nxt = locked;
        valid_nxt  = 1'b0;
        range_nxt  = 1'b0;
        tmo_nxt    = 1'b0;
        if (!en) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            run_nxt    = '0;
            locked_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARMED;
                    cnt_nxt   = '0;
                end
                ARMED: begin
                    if (tick_edge) begin
                        cnt_nxt   = '0;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (tick_edge) begin
                        cnt_nxt    = '0;
                        valid_nxt  = 1'b1;
                        period_nxt = period_now;
                        if (in_range) begin
                            if (run < RUN_W'(LOCK_COUNT)) begin
                                run_nxt = run + RUN_W'(1);
                            end
                            locked_nxt = (run_nxt >= RUN_W'(LOCK_COUNT));
                        end else begin
                            range_nxt  = 1'b1;
                            run_nxt    = '0;
                            locked_nxt = 1'b0;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CNT)) begin
                        tmo_nxt    = 1'b1;
                        run_nxt    = '0;
                        locked_nxt = 1'b0;
                        cnt_nxt    = '0;
                        state_nxt  = ARMED;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
        // A strobe being issued or currently visible keeps the sticky flag set
        sticky_nxt = range_nxt | tmo_nxt | err_range | err_timeout |
                     (err_sticky & ~clr_err);
    end

    // State register and registered outputs
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            run          <= '0;
            tick_d       <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err_range    <= 1'b0;
            err_timeout  <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            run          <= run_nxt;
            tick_d       <= tick_in;
            period_out   <= period_nxt;
            period_valid <= valid_nxt;
            locked       <= locked_nxt;
            err_range    <= range_nxt;
            err_timeout  <= tmo_nxt;
            err_sticky   <= sticky_nxt;
        end
    end

`ifdef TICK_PERIOD_STATS_EN
    // Min/max of completed intervals; a period arriving with clr_err restarts the stats
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            period_min <= '1;
            period_max <= '0;
        end else if (valid_nxt) begin
            if (clr_err) begin
                period_min <= period_now;
                period_max <= period_now;
            end else begin
                if (period_now < period_min) begin
                    period_min <= period_now;
                end
                if (period_now > period_max) begin
                    period_max <= period_now;
                end
            end
        end else if (clr_err) begin
            period_min <= '1;
            period_max <= '0;
        end
    end
`else
    assign period_min = '0;
    assign period_max = '0;
`endif

endmodule
